imem_prog: RTL and testbench

- Parametrised, loadable instruction memory for the core's fetch stage.
- Replaces the hard-wired program table with a boot sequence: clear-on-reset, then an external program-load phase, then a run phase.
- In the run phase it serves registered fetches with a valid/fault response.
- Sits between the program loader (testbench or host) and the core's PC/fetch logic.

---
 rtl/imem_pkg.sv | 13 +
 rtl/imem_array.sv | 49 ++++
 rtl/imem_prog.sv | 126 ++++++++++++
 tb/tb_imem_prog.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory: boot-phase encoding
// and the NOP instruction word that the core decoder also reuses.
package imem_pkg;

  typedef enum logic [1:0] {
    IMEM_CLEAR = 2'd0,
    IMEM_LOAD  = 2'd1,
    IMEM_RUN   = 2'd2
  } imem_state_e;

  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W instruction storage: one write port, one registered read port
// whose output can be forced to the NOP word for out-of-range fetches.
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        DEPTH    = 16,
  parameter int unsigned        IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(IMEM_NOP_WORD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic              rd_nop,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  // Storage carries no reset; the owner clears it word by word after reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = rd_nop ? NOP_WORD : mem_q[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= NOP_WORD;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_prog.sv
// Loadable instruction memory: clears on reset, accepts an external program
// load, then serves latency-1 registered fetches with a fault flag.
module imem_prog
  import imem_pkg::*;
#(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        ADDR_W   = 16,
  parameter int unsigned        DEPTH    = 16,
  parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(IMEM_NOP_WORD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done,
  output logic              ld_ready,
  output logic              ld_err,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_fault,
  output logic              running
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  imem_state_e      state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             ld_err_q, ld_err_d;
  logic             valid_q, valid_d;
  logic             fault_q, fault_d;

  logic              ld_in_range, fetch_in_range;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;

  // One extra bit keeps the compare exact even when DEPTH == 2**ADDR_W.
  assign ld_in_range    = ({1'b0, ld_addr}    < (ADDR_W+1)'(DEPTH));
  assign fetch_in_range = ({1'b0, fetch_addr} < (ADDR_W+1)'(DEPTH));

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ld_err_d  = ld_err_q;
    valid_d   = 1'b0;
    fault_d   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = clr_cnt_q;
    mem_wdata = NOP_WORD;
    mem_re    = 1'b0;
    unique case (state_q)
      IMEM_CLEAR: begin
        mem_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + IDX_W'(1);
        if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
          clr_cnt_d = '0;
          state_d   = IMEM_LOAD;
        end
      end
      IMEM_LOAD: begin
        if (ld_we) begin
          if (ld_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = ld_addr[IDX_W-1:0];
            mem_wdata = ld_data;
          end else begin
            ld_err_d = 1'b1;
          end
        end
        if (ld_done) begin
          state_d = IMEM_RUN;
        end
      end
      IMEM_RUN: begin
        mem_re  = fetch_req;
        valid_d = fetch_req;
        fault_d = fetch_req && !fetch_in_range;
      end
      default: state_d = IMEM_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IMEM_CLEAR;
      clr_cnt_q <= '0;
      ld_err_q  <= 1'b0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ld_err_q  <= ld_err_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
    end
  end

  imem_array #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .IDX_W    (IDX_W),
    .NOP_WORD (NOP_WORD)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (mem_we && rst_n),
    .waddr  (mem_waddr),
    .wdata  (mem_wdata),
    .re     (mem_re),
    .rd_nop (!fetch_in_range),
    .raddr  (fetch_addr[IDX_W-1:0]),
    .rdata  (fetch_data)
  );

  assign ld_ready    = (state_q == IMEM_LOAD);
  assign running     = (state_q == IMEM_RUN);
  assign ld_err      = ld_err_q;
  assign fetch_valid = valid_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_imem_prog.sv
// Randomized self-checking bench for imem_prog against a phase-level
// reference model of the clear / load / run boot sequence.
module tb_imem_prog;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH  = 16;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_done;
  logic              ld_ready;
  logic              ld_err;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_fault;
  logic              running;

  imem_prog #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_we       (ld_we),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_done     (ld_done),
    .ld_ready    (ld_ready),
    .ld_err      (ld_err),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_fault (fetch_fault),
    .running     (running)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: boot phase, cycles left in clear, program contents.
  typedef enum {PH_CLEAR, PH_LOAD, PH_RUN} phase_e;
  phase_e      m_phase;
  int unsigned m_clear_left;
  logic [31:0] m_mem [DEPTH];
  logic        m_err, m_valid, m_fault;
  logic [31:0] m_data;

  task automatic model_edge();
    if (!rst_n) begin
      m_phase      = PH_CLEAR;
      m_clear_left = DEPTH;
      foreach (m_mem[i]) m_mem[i] = NOP;
      m_err   = 1'b0;
      m_valid = 1'b0;
      m_fault = 1'b0;
      m_data  = NOP;
      return;
    end
    m_valid = 1'b0;
    m_fault = 1'b0;
    case (m_phase)
      PH_CLEAR: begin
        m_clear_left--;
        if (m_clear_left == 0) m_phase = PH_LOAD;
      end
      PH_LOAD: begin
        if (ld_we) begin
          if (int'(ld_addr) < int'(DEPTH)) m_mem[ld_addr] = ld_data;
          else m_err = 1'b1;
        end
        if (ld_done) m_phase = PH_RUN;
      end
      PH_RUN: begin
        if (fetch_req) begin
          m_valid = 1'b1;
          if (int'(fetch_addr) < int'(DEPTH)) begin
            m_data = m_mem[fetch_addr];
          end else begin
            m_data  = NOP;
            m_fault = 1'b1;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("ld_ready", 32'(ld_ready), 32'(m_phase == PH_LOAD));
    check("running", 32'(running), 32'(m_phase == PH_RUN));
    check("ld_err", 32'(ld_err), 32'(m_err));
    check("fetch_valid", 32'(fetch_valid), 32'(m_valid));
    check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    check("fetch_data", fetch_data, m_data);
  endtask

  task automatic idle();
    ld_we = 1'b0; ld_done = 1'b0; fetch_req = 1'b0;
  endtask

  task automatic noise();
    ld_we      = 1'($urandom);
    ld_done    = 1'($urandom);
    ld_addr    = 16'($urandom_range(0, 31));
    ld_data    = $urandom;
    fetch_req  = 1'($urandom);
    fetch_addr = 16'($urandom_range(0, 31));
  endtask

  // Steps through CLEAR with noise on all inputs and measures its length.
  task automatic clear_phase(input string tag);
    int unsigned n = 0;
    do begin
      noise();
      step();
      n++;
    end while (!ld_ready && n < 40);
    check(tag, n, DEPTH);
    idle();
  endtask

  task automatic load(input int unsigned a, input logic [31:0] d, input logic done);
    ld_we = 1'b1; ld_addr = 16'(a); ld_data = d; ld_done = done;
    fetch_req = 1'($urandom); fetch_addr = 16'($urandom_range(0, 20));
    step();
    idle();
  endtask

  task automatic fetch(input int unsigned a);
    fetch_req = 1'b1; fetch_addr = 16'(a);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    ld_addr = '0; ld_data = '0; fetch_addr = '0;
    step();
    step();
    check("rst_data", fetch_data, NOP);
    rst_n = 1'b1;
    clear_phase("clr_len");

    load(0, 32'h0001_0005, 1'b0);
    load(1, 32'h0020_1000, 1'b0);
    load(20, 32'h1234_5678, 1'b0);
    check("ld_err_sticky", 32'(ld_err), 32'd1);
    for (int i = 0; i < 8; i++) load($urandom_range(4, 23), $urandom, 1'b0);
    load(3, 32'hDEAD_BEEF, 1'b1);
    check("in_run", 32'(running), 32'd1);

    fetch(0);
    check("f0", fetch_data, 32'h0001_0005);
    fetch(1);
    check("f1", fetch_data, 32'h0020_1000);
    fetch(2);
    check("f2", fetch_data, NOP);
    fetch(3);
    check("f3", fetch_data, 32'hDEAD_BEEF);
    fetch(20);
    check("f20_fault", 32'(fetch_fault), 32'd1);
    fetch(16'hFFFF);
    idle();
    ld_we = 1'b1; ld_addr = 16'd3; ld_data = 32'h0BAD_0BAD; ld_done = 1'b1;
    step();
    idle();
    fetch(3);
    check("ro_run", fetch_data, 32'hDEAD_BEEF);

    for (int i = 0; i < 80; i++) begin
      noise();
      fetch_req = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) fetch_addr = 16'($urandom_range(16, 65535));
      step();
    end

    fetch(3);
    fetch_req = 1'b1; fetch_addr = 16'd0; rst_n = 1'b0;
    step();
    check("rst_drop", 32'(fetch_valid), 32'd0);
    rst_n = 1'b1;
    clear_phase("clr_len2");
    ld_done = 1'b1;
    step();
    idle();
    for (int unsigned a = 0; a < DEPTH; a++) fetch(a);
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
